buzzer_timebase: RTL and testbench



---
 rtl/buzzer_pkg.sv | 14 +
 rtl/elapsed_counter.sv | 37 +++
 rtl/buzzer_timebase.sv | 39 +++
 tb/tb_buzzer_timebase.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared clock basis for the buzzer subsystem: sequencer, tone dividers and timebase
// all derive their cycle counts from these constants.
package buzzer_pkg;

  localparam int unsigned CLK_HZ       = 32_768_000;
  localparam int unsigned SHORT_CYCLES = 4_096_000;    // 125 ms at CLK_HZ
  localparam int unsigned LONG_CYCLES  = 491_520_000;  // 15 s at CLK_HZ

  // Bits needed to hold the value n itself (0..n inclusive).
  function automatic int unsigned count_width(input longint unsigned n);
    return $clog2(n + 64'd1);
  endfunction

endpackage

// File: rtl/elapsed_counter.sv
// Saturating elapsed-cycle counter with synchronous restart; done is a registered
// flag that stays high from the Nth uncleared edge until the next clear.
module elapsed_counter
  import buzzer_pkg::*;
#(
  parameter int unsigned N = 1,
  parameter int unsigned W = count_width(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic done
);

  if (N < 1) begin : g_bad_n
    $error("elapsed_counter: N must be at least 1");
  end
  if (W < count_width(N)) begin : g_bad_w
    $error("elapsed_counter: W too narrow to hold N");
  end

  localparam logic [W-1:0] NVal = W'(N);

  logic [W-1:0] cnt_q;

  // Clear beats counting, so a clear on the completing edge keeps done low.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
      done  <= 1'b0;
    end else if (cnt_q < NVal) begin
      cnt_q <= cnt_q + W'(1);
      done  <= ((cnt_q + W'(1)) == NVal);
    end
  end

endmodule

// File: rtl/buzzer_timebase.sv
// Dual timebase for the buzzer sequencer: channel S times a note segment,
// channel L times the long interval. Channels share only clock and reset.
module buzzer_timebase
  import buzzer_pkg::*;
#(
  parameter int unsigned SHORT_CYCLES = buzzer_pkg::SHORT_CYCLES,
  parameter int unsigned LONG_CYCLES  = buzzer_pkg::LONG_CYCLES,
  parameter int unsigned SHORT_W      = count_width(SHORT_CYCLES),
  parameter int unsigned LONG_W       = count_width(LONG_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic short_clr,
  input  logic long_clr,
  output logic short_done,
  output logic long_done
);

  elapsed_counter #(
    .N (SHORT_CYCLES),
    .W (SHORT_W)
  ) u_short (
    .clk   (clk),
    .reset (reset),
    .clr   (short_clr),
    .done  (short_done)
  );

  elapsed_counter #(
    .N (LONG_CYCLES),
    .W (LONG_W)
  ) u_long (
    .clk   (clk),
    .reset (reset),
    .clr   (long_clr),
    .done  (long_done)
  );

endmodule

// File: tb/tb_buzzer_timebase.sv
// Bench for buzzer_timebase: a (5,12) build and a (1,12) build checked every cycle
// against an edges-since-clear model, plus literal checkpoints for the directed cases.
module tb_buzzer_timebase;

  logic clk = 1'b0;
  logic reset;
  logic short_clr, long_clr, short_clr1, long_clr1;
  logic short_done, long_done, short_done1, long_done1;

  always #5 clk = ~clk;

  buzzer_timebase #(
    .SHORT_CYCLES (5),
    .LONG_CYCLES  (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .short_clr  (short_clr),
    .long_clr   (long_clr),
    .short_done (short_done),
    .long_done  (long_done)
  );

  buzzer_timebase #(
    .SHORT_CYCLES (1),
    .LONG_CYCLES  (12)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .short_clr  (short_clr1),
    .long_clr   (long_clr1),
    .short_done (short_done1),
    .long_done  (long_done1)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel is done once it has seen N consecutive uncleared edges.
  int unsigned n_of [4] = '{5, 12, 1, 12};
  int unsigned run [4] = '{0, 0, 0, 0};
  logic [3:0] clr_v, done_v;
  assign clr_v  = {long_clr1, short_clr1, long_clr, short_clr};
  assign done_v = {long_done1, short_done1, long_done, short_done};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || clr_v[i]) run[i] <= 0;
      else if (run[i] < 100000) run[i] <= run[i] + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("model ch%0d", i), done_v[i], logic'(run[i] >= n_of[i]));
      end
    end
  end

  // Advance one rising edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; short_clr = 1'b0; long_clr = 1'b0;
    short_clr1 = 1'b1; long_clr1 = 1'b0;
    tick();
    chk_en = 1'b1;
    ticks(2);
    check("reset short_done", short_done, 1'b0);
    check("reset long_done", long_done, 1'b0);

    // Release reset: short rises on edge 5, long on edge 12.
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4)  check("short edge4", short_done, 1'b0);
      if (k == 5)  check("short edge5", short_done, 1'b1);
      if (k == 11) check("long edge11", long_done, 1'b0);
      if (k == 12) check("long edge12", long_done, 1'b1);
    end
    ticks(20);
    check("short held", short_done, 1'b1);
    check("long held", long_done, 1'b1);

    // Long idle hold on short channel.
    short_clr = 1'b1;
    ticks(10);
    check("short in hold", short_done, 1'b0);
    short_clr = 1'b0;
    ticks(4);
    check("short 4 after hold", short_done, 1'b0);
    tick();
    check("short 5 after hold", short_done, 1'b1);
    check("long unaffected", long_done, 1'b1);

    // Mid-count pulse on edge 3 of a fresh count: done arrives on edge 8.
    short_clr = 1'b1; tick(); short_clr = 1'b0;
    ticks(2);
    short_clr = 1'b1; tick(); short_clr = 1'b0;
    ticks(4);
    check("pulse edge7", short_done, 1'b0);
    tick();
    check("pulse edge8", short_done, 1'b1);

    // Sequencer-style note stepping.
    for (int r = 0; r < 4; r++) begin
      short_clr = 1'b1; tick(); short_clr = 1'b0;
      check("step cleared", short_done, 1'b0);
      ticks(4);
      check("step early", short_done, 1'b0);
      tick();
      check("step rise", short_done, 1'b1);
    end

    // Global reset pulse after long completion.
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst pulse short", short_done, 1'b0);
    check("rst pulse long", long_done, 1'b0);
    ticks(5);
    check("rst short rise", short_done, 1'b1);
    check("rst long early", long_done, 1'b0);
    ticks(7);
    check("rst long rise", long_done, 1'b1);

    // N = 1 build: done on the very first released edge; clear on that edge wins.
    short_clr1 = 1'b0; tick();
    check("n1 first edge", short_done1, 1'b1);
    short_clr1 = 1'b1; tick();
    check("n1 clear", short_done1, 1'b0);
    tick();
    check("n1 clear held", short_done1, 1'b0);
    short_clr1 = 1'b0; tick();
    check("n1 re-rise", short_done1, 1'b1);

    // Randomized traffic on all four channels, checked by the model every cycle.
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      short_clr  = ($urandom_range(0, 7) == 0);
      long_clr   = ($urandom_range(0, 19) == 0);
      short_clr1 = ($urandom_range(0, 2) == 0);
      long_clr1  = ($urandom_range(0, 15) == 0);
      tick();
    end
    reset = 1'b0; short_clr = 1'b0; long_clr = 1'b0; short_clr1 = 1'b0; long_clr1 = 1'b0;
    ticks(15);
    check("final short", short_done, 1'b1);
    check("final long", long_done, 1'b1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
